// File: rtl/slice_mux_seq.sv
// slice_mux_seq: registered N-channel operand-slice selector.
//
// state | meaning
// IDLE  | manual selection (mode=0) or waiting for a sweep start (mode=1)
// RUN   | sweep in progress, emitting shadow slices 1..NUM_CH-1
//
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   mux_in       : NUM_CH packed slices of WIDTH bits, slice k at [k*WIDTH +: WIDTH]
//   mux_sel      : manual-mode slice index
//   mode         : 0 = manual, 1 = sweep (looked at only in IDLE)
//   start        : begins a sweep in IDLE when mode=1
//   hold         : stalls the sweep for one cycle while in RUN
//   mux_out      : registered slice
//   mux_out_sel  : index of the slice on mux_out
//   mux_valid    : mux_out carries a fresh slice this cycle
//   busy         : high while in RUN
//   done         : pulse alongside the last slice of a sweep
module slice_mux_seq #(
  parameter  int WIDTH  = 4,
  parameter  int NUM_CH = 4,
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH*WIDTH-1:0] mux_in,
  input  logic [SEL_W-1:0]        mux_sel,
  input  logic                    mode,
  input  logic                    start,
  input  logic                    hold,
  output logic [WIDTH-1:0]        mux_out,
  output logic [SEL_W-1:0]        mux_out_sel,
  output logic                    mux_valid,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  state_t                  state_q, state_d;
  logic [NUM_CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [SEL_W-1:0]        idx_q, idx_d;
  logic [WIDTH-1:0]        out_q, out_d;
  logic [SEL_W-1:0]        out_sel_q, out_sel_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    sel_ok;

  function automatic logic [WIDTH-1:0] pick(input logic [NUM_CH*WIDTH-1:0] bus,
                                            input logic [SEL_W-1:0] sel);
    pick = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) pick = bus[k*WIDTH +: WIDTH];
    end
  endfunction

  // Only meaningful when NUM_CH is not a power of two.
  assign sel_ok = (int'(mux_sel) < NUM_CH);

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    out_d     = out_q;
    out_sel_d = out_sel_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!mode) begin
          out_sel_d = mux_sel;
          if (sel_ok) begin
            out_d   = pick(mux_in, mux_sel);
            valid_d = 1'b1;
          end else begin
            out_d = '0;
          end
        end else if (start) begin
          // Slice 0 goes out straight from mux_in; the shadow feeds the rest.
          shadow_d  = mux_in;
          out_d     = mux_in[WIDTH-1:0];
          out_sel_d = '0;
          valid_d   = 1'b1;
          if (NUM_CH == 1) begin
            done_d = 1'b1;
          end else begin
            idx_d   = SEL_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          out_d     = pick(shadow_q, idx_q);
          out_sel_d = idx_q;
          valid_d   = 1'b1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      out_q     <= '0;
      out_sel_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      out_q     <= out_d;
      out_sel_q <= out_sel_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign mux_out     = out_q;
  assign mux_out_sel = out_sel_q;
  assign mux_valid   = valid_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_slice_mux_seq.sv
// Directed bench for slice_mux_seq: a 4x4-bit instance and a 3x8-bit instance.
// Each step drives inputs, pushes the expected post-edge outputs to a queue,
// then pops and compares one time unit after the edge.
module tb_slice_mux_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4 channels x 4 bits
  logic        rst_a, mode_a, start_a, hold_a;
  logic [15:0] in_a;
  logic [1:0]  sel_a;
  logic [3:0]  out_a;
  logic [1:0]  osel_a;
  logic        v_a, b_a, d_a;

  // 3 channels x 8 bits
  logic        rst_b, mode_b, start_b, hold_b;
  logic [23:0] in_b;
  logic [1:0]  sel_b;
  logic [7:0]  out_b;
  logic [1:0]  osel_b;
  logic        v_b, b_b, d_b;

  slice_mux_seq #(.WIDTH(4), .NUM_CH(4)) dut_a (
    .clk(clk), .reset(rst_a), .mux_in(in_a), .mux_sel(sel_a), .mode(mode_a),
    .start(start_a), .hold(hold_a), .mux_out(out_a), .mux_out_sel(osel_a),
    .mux_valid(v_a), .busy(b_a), .done(d_a));

  slice_mux_seq #(.WIDTH(8), .NUM_CH(3)) dut_b (
    .clk(clk), .reset(rst_b), .mux_in(in_b), .mux_sel(sel_b), .mode(mode_b),
    .start(start_b), .hold(hold_b), .mux_out(out_b), .mux_out_sel(osel_b),
    .mux_valid(v_b), .busy(b_b), .done(d_b));

  typedef struct {
    string       tag;
    logic [15:0] exp;
    logic [15:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  // vector layout: {out, out_sel[1:0], valid, busy, done}
  task automatic check(input logic [15:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=entry", obs);
      return;
    end
    e = sb_q.pop_front();
    n_cmp++;
    assert ((obs & e.mask) === (e.exp & e.mask))
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.exp & e.mask);
    end
  endtask

  task automatic step_a(input string tag, input logic r, input logic m, input logic s,
                        input logic h, input logic [1:0] sel, input logic [15:0] din,
                        input logic [3:0] eo, input logic [1:0] es,
                        input logic ev, input logic eb, input logic ed);
    sb_t e;
    rst_a = r; mode_a = m; start_a = s; hold_a = h; sel_a = sel; in_a = din;
    e.tag  = tag;
    e.exp  = {7'd0, eo, es, ev, eb, ed};
    e.mask = 16'h01FF;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check({7'd0, out_a, osel_a, v_a, b_a, d_a});
  endtask

  task automatic step_b(input string tag, input logic r, input logic m, input logic s,
                        input logic [1:0] sel, input logic [23:0] din, input logic chk_sel,
                        input logic [7:0] eo, input logic [1:0] es,
                        input logic ev, input logic eb, input logic ed);
    sb_t e;
    rst_b = r; mode_b = m; start_b = s; hold_b = 1'b0; sel_b = sel; in_b = din;
    e.tag  = tag;
    e.exp  = {3'd0, eo, es, ev, eb, ed};
    e.mask = chk_sel ? 16'h1FFF : 16'h1FE7;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check({3'd0, out_b, osel_b, v_b, b_b, d_b});
  endtask

  initial begin
    rst_b = 1'b1; mode_b = 1'b0; start_b = 1'b0; hold_b = 1'b0; sel_b = '0; in_b = '0;

    //        tag           r  m  s  h  sel   in        out   sel v  b  d
    step_a("reset0",       1, 0, 0, 0, 2'd0, 16'hD7CA, 4'h0, 0, 0, 0, 0);
    step_a("reset1",       1, 1, 1, 1, 2'd2, 16'hD7CA, 4'h0, 0, 0, 0, 0);

    step_a("man_sel0",     0, 0, 0, 0, 2'd0, 16'hD7CA, 4'hA, 0, 1, 0, 0);
    step_a("man_sel1",     0, 0, 1, 0, 2'd1, 16'hD7CA, 4'hC, 1, 1, 0, 0);
    step_a("man_sel2",     0, 0, 0, 1, 2'd2, 16'hD7CA, 4'h7, 2, 1, 0, 0);
    step_a("man_sel3",     0, 0, 0, 0, 2'd3, 16'hD7CA, 4'hD, 3, 1, 0, 0);

    step_a("sw_start",     0, 1, 1, 0, 2'd0, 16'hD7CA, 4'hA, 0, 1, 1, 0);
    step_a("sw_s1",        0, 1, 0, 0, 2'd0, 16'h0000, 4'hC, 1, 1, 1, 0);
    step_a("sw_s2",        0, 1, 0, 0, 2'd0, 16'h0000, 4'h7, 2, 1, 1, 0);
    step_a("sw_s3_done",   0, 1, 0, 0, 2'd0, 16'h0000, 4'hD, 3, 1, 0, 1);
    step_a("sw_idle",      0, 1, 0, 0, 2'd0, 16'h0000, 4'hD, 3, 0, 0, 0);

    step_a("hd_start",     0, 1, 1, 0, 2'd0, 16'hD7CA, 4'hA, 0, 1, 1, 0);
    step_a("hd_hold1",     0, 1, 0, 1, 2'd0, 16'h0000, 4'hA, 0, 0, 1, 0);
    step_a("hd_hold2",     0, 1, 0, 1, 2'd0, 16'h0000, 4'hA, 0, 0, 1, 0);
    step_a("hd_s1",        0, 1, 0, 0, 2'd0, 16'h0000, 4'hC, 1, 1, 1, 0);
    step_a("hd_s2",        0, 1, 0, 0, 2'd0, 16'h0000, 4'h7, 2, 1, 1, 0);
    step_a("hd_s3_done",   0, 1, 0, 0, 2'd0, 16'h0000, 4'hD, 3, 1, 0, 1);
    step_a("hd_idle",      0, 1, 0, 0, 2'd0, 16'h0000, 4'hD, 3, 0, 0, 0);

    step_a("rm_start",     0, 1, 1, 0, 2'd0, 16'hD7CA, 4'hA, 0, 1, 1, 0);
    step_a("rm_s1",        0, 1, 0, 0, 2'd0, 16'hD7CA, 4'hC, 1, 1, 1, 0);
    step_a("rm_reset",     1, 1, 0, 0, 2'd0, 16'hD7CA, 4'h0, 0, 0, 0, 0);
    step_a("rm_after",     0, 1, 0, 0, 2'd0, 16'hD7CA, 4'h0, 0, 0, 0, 0);
    step_a("rm_after2",    0, 1, 0, 0, 2'd0, 16'hD7CA, 4'h0, 0, 0, 0, 0);
    step_a("rs_start",     0, 1, 1, 0, 2'd0, 16'h1234, 4'h4, 0, 1, 1, 0);
    step_a("rs_s1",        0, 1, 0, 0, 2'd0, 16'h1234, 4'h3, 1, 1, 1, 0);
    step_a("rs_s2",        0, 1, 0, 0, 2'd0, 16'h1234, 4'h2, 2, 1, 1, 0);
    step_a("rs_s3_done",   0, 1, 0, 0, 2'd0, 16'h1234, 4'h1, 3, 1, 0, 1);

    step_a("ig_start",     0, 1, 1, 0, 2'd3, 16'hD7CA, 4'hA, 0, 1, 1, 0);
    step_a("ig_s1",        0, 0, 1, 0, 2'd3, 16'h1234, 4'hC, 1, 1, 1, 0);
    step_a("ig_s2",        0, 0, 1, 0, 2'd0, 16'h1234, 4'h7, 2, 1, 1, 0);
    step_a("ig_s3_done",   0, 1, 1, 0, 2'd1, 16'h1234, 4'hD, 3, 1, 0, 1);
    step_a("b2b_start",    0, 1, 1, 0, 2'd2, 16'hFFFF, 4'hF, 0, 1, 1, 0);
    step_a("b2b_s1",       0, 1, 0, 0, 2'd0, 16'h0000, 4'hF, 1, 1, 1, 0);
    step_a("b2b_s2",       0, 1, 0, 0, 2'd0, 16'h0000, 4'hF, 2, 1, 1, 0);
    step_a("b2b_s3_done",  0, 1, 0, 0, 2'd0, 16'h0000, 4'hF, 3, 1, 0, 1);
    step_a("b2b_idle",     0, 1, 0, 0, 2'd0, 16'h0000, 4'hF, 3, 0, 0, 0);
    step_a("man_back",     0, 0, 0, 0, 2'd2, 16'h1234, 4'h2, 2, 1, 0, 0);

    //        tag           r  m  s  sel   in          chk  out    sel v  b  d
    step_b("n3_reset",     1, 0, 0, 2'd0, 24'h112233, 1,   8'h00, 0, 0, 0, 0);
    step_b("n3_man1",      0, 0, 0, 2'd1, 24'h112233, 1,   8'h22, 1, 1, 0, 0);
    step_b("n3_man2",      0, 0, 0, 2'd2, 24'h112233, 1,   8'h11, 2, 1, 0, 0);
    step_b("n3_man_oor",   0, 0, 0, 2'd3, 24'h112233, 0,   8'h00, 0, 0, 0, 0);
    step_b("n3_start",     0, 1, 1, 2'd3, 24'h112233, 1,   8'h33, 0, 1, 1, 0);
    step_b("n3_s1",        0, 1, 0, 2'd0, 24'h000000, 1,   8'h22, 1, 1, 1, 0);
    step_b("n3_s2_done",   0, 1, 0, 2'd0, 24'h000000, 1,   8'h11, 2, 1, 0, 1);
    step_b("n3_idle",      0, 1, 0, 2'd0, 24'h000000, 1,   8'h11, 2, 0, 0, 0);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
